// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register file write port among NUM_REQ writeback sources.
// Defining REGFILE_WB_ARB_BYPASS_EN adds two forwarding ports that expose the pending registered write.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         rf_hold,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         rf_reg_write,
    output logic [ADDR_W-1:0]            rf_write_addr,
    output logic [DATA_W-1:0]            rf_write_data,
    output logic [$clog2(NUM_REQ)-1:0]   last_grant
`ifdef REGFILE_WB_ARB_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]            rd_addr_1,
    input  logic [ADDR_W-1:0]            rd_addr_2,
    output logic                         fwd_hit_1,
    output logic                         fwd_hit_2,
    output logic [DATA_W-1:0]            fwd_data_1,
    output logic [DATA_W-1:0]            fwd_data_2
`endif
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]  last_grant_q, last_grant_d, idx, win;
    logic              found;
    logic [ADDR_W-1:0] sel_addr, rf_write_addr_q, rf_write_addr_d;
    logic [DATA_W-1:0] sel_data, rf_write_data_q, rf_write_data_d;
    logic              rf_reg_write_q, rf_reg_write_d;

    // Search begins just after the last winner so every requester rotates to top priority.
    always_comb begin
        req_ready = '0;
        found     = 1'b0;
        idx       = '0;
        win       = last_grant_q;
        sel_addr  = '0;
        sel_data  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!found && !rf_hold && req_valid[idx]) begin
                found          = 1'b1;
                win            = idx;
                req_ready[idx] = 1'b1;
                sel_addr       = req_addr[int'(idx)*ADDR_W +: ADDR_W];
                sel_data       = req_data[int'(idx)*DATA_W +: DATA_W];
            end
        end
        rf_reg_write_d  = found && (sel_addr != '0);
        rf_write_addr_d = found ? sel_addr : rf_write_addr_q;
        rf_write_data_d = found ? sel_data : rf_write_data_q;
        last_grant_d    = win;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_reg_write_q  <= 1'b0;
            rf_write_addr_q <= '0;
            rf_write_data_q <= '0;
            last_grant_q    <= IDX_W'(NUM_REQ - 1);
        end else begin
            rf_reg_write_q  <= rf_reg_write_d;
            rf_write_addr_q <= rf_write_addr_d;
            rf_write_data_q <= rf_write_data_d;
            last_grant_q    <= last_grant_d;
        end
    end

    assign rf_reg_write  = rf_reg_write_q;
    assign rf_write_addr = rf_write_addr_q;
    assign rf_write_data = rf_write_data_q;
    assign last_grant    = last_grant_q;

`ifdef REGFILE_WB_ARB_BYPASS_EN
    assign fwd_hit_1  = rf_reg_write_q && (rf_write_addr_q == rd_addr_1) && (rd_addr_1 != '0);
    assign fwd_hit_2  = rf_reg_write_q && (rf_write_addr_q == rd_addr_2) && (rd_addr_2 != '0);
    assign fwd_data_1 = fwd_hit_1 ? rf_write_data_q : '0;
    assign fwd_data_2 = fwd_hit_2 ? rf_write_data_q : '0;
`endif
endmodule
